ctl_shot: RTL and testbench
===========================

# ctl_shot

Shot controller for the duck-hunt game and the producer of the `hit` input consumed by the duck controller. It synchronises the gun trigger and tests the aim point against the duck bounding box on each trigger press. It issues a single-cycle `hit` or `miss` pulse per shot and tracks ammunition per duck, plus an optional score. Sits in the control layer between the input front-end (mouse/zapper) and the duck and draw controllers.

## Interface
Parameters:
- `DUCK_W`, 64: duck sprite width in pixels; hit box spans x in [duck_x, duck_x+DUCK_W).
- `DUCK_H`, 64: duck sprite height in pixels; hit box spans y in [duck_y, duck_y+DUCK_H).
- `AMMO_MAX`, 3: shots available per duck, 1..3.
- `COOLDOWN_FRAMES`, 8: `new_frame` pulses during which further triggers are ignored after a shot, 1..15.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `new_frame`  in  1  one-cycle pulse per video frame
- `game_start`  in  1  one-cycle pulse; starts or restarts the game
- `trigger`  in  1  raw asynchronous trigger level, active-high
- `aim_x`  in  10  crosshair x
- `aim_y`  in  10  crosshair y
- `duck_x`  in  10  duck top-left x
- `duck_y`  in  10  duck top-left y
- `duck_show`  in  1  duck visible
- `duck_hit`  in  1  duck is currently falling
- `hit`  out  1  one-cycle pulse: shot landed
- `miss`  out  1  one-cycle pulse: shot missed
- `shot_fired`  out  1  one-cycle pulse per accepted shot (sound trigger)
- `ammo`  out  2  rounds remaining
- `score`  out  8  ducks hit since `game_start`, saturating

## Operation
- Trigger path:
  - 2-FF synchroniser, then a rising-edge detector.
  - Only rising edges count; holding `trigger` fires once.
- States: IDLE, READY, EVAL, COOLDOWN, EMPTY.
- IDLE:
  - Leaves only on `game_start`, going to READY.
  - `ammo` = AMMO_MAX.
- READY:
  - A trigger edge is accepted only when `duck_show`=1 and `duck_hit`=0.
  - On acceptance: latch aim_x/aim_y/duck_x/duck_y into registers, decrement `ammo`, go to EVAL.
  - Edges arriving when the acceptance conditions are false are dropped and consume no ammo.
- EVAL (exactly 1 cycle):
  - Compare on the latched values using 11-bit unsigned arithmetic, so duck_x+DUCK_W does not wrap.
  - Inside the box: register `hit`=1 and increment `score`.
  - Outside the box: register `miss`=1.
  - Then go to COOLDOWN.
- COOLDOWN:
  - Counts `new_frame` pulses; after COOLDOWN_FRAMES pulses, go to READY if `ammo`>0, else EMPTY.
  - Trigger edges are dropped.
- EMPTY:
  - Triggers are dropped.
  - Waits for a reload.
- Reload:
  - Occurs on a rising edge of `duck_show` (a new duck).
  - Sets `ammo` = AMMO_MAX.
  - From EMPTY it goes to READY; from READY or COOLDOWN the state is unchanged.
- `score`:
  - Saturates at 255 and never wraps.
  - Cleared only by `rst` or `game_start`.
- `game_start` in any non-IDLE state:
  - `ammo` = AMMO_MAX, `score` = 0, cooldown counter = 0, state goes to READY.
  - Any in-flight EVAL is discarded with no pulse.
- Priority in a single cycle: `rst` > `game_start` > reload > trigger edge.
  - A reload and a trigger edge in the same cycle: the reload is applied and the edge is dropped.

## Timing
- Reset values:
  - Outputs: `hit`=0, `miss`=0, `shot_fired`=0, `ammo`=AMMO_MAX, `score`=0.
  - Internal: state IDLE; synchroniser flops and edge flop 0.
- Trigger latency, with the trigger rise first sampled at clock edge k:
  - Edge k+2: edge detected; state goes to EVAL; `shot_fired` pulses; `ammo` decrements.
  - Edge k+3: `hit` or `miss` pulses for exactly one cycle.
- `hit`, `miss` and `shot_fired` are registered outputs with no combinational path from the inputs.
- `hit` and `miss` are mutually exclusive; exactly one of them follows every `shot_fired`, unless `game_start` intervenes.
- The duck controller edge-detects `hit`, so a one-cycle pulse is sufficient.
- COOLDOWN duration is COOLDOWN_FRAMES `new_frame` pulses. A `new_frame` arriving in the EVAL cycle is not counted.
- Reset applied mid-EVAL: no pulse is produced.

## Configuration
- `CTL_SHOT_SCORE_EN` defined:
  - 8-bit score register is present.
  - Behaves as described under Operation.
- Not defined:
  - No score register; `score` is tied to 0.
  - All other behaviour is identical.

## Structure
- Shared package `duck_hunt_pkg` holds:
  - the state enum type for this block;
  - DUCK_W, DUCK_H, AMMO_MAX defaults;
  - the screen limits X_POS_MAX=1024 and Y_POS_MAX=600.
- One sub-module, `sync_edge`:
  - 2-FF synchroniser plus rising-edge pulse, with synchronous reset.
  - Reused later for other asynchronous player inputs.

## Test plan
- Duck at (100,200), showing. Aim (130,230), trigger held for 20 cycles -> `shot_fired` at edge k+2, one `hit` at k+3, `ammo` 3->2, `score` 0->1, no second shot.
- Aim (164,230), duck at (100,200) -> `miss` pulse, no `hit`; boundary x = duck_x+DUCK_W is outside the box.
- Duck at (1000,590), aim (1020,599) -> `hit`, with no wrap error in the 11-bit compare.
- Three misses -> `ammo`=0, state EMPTY, fourth trigger ignored; `duck_show` 0->1 -> `ammo`=3, fourth trigger accepted.
- Trigger edges during COOLDOWN (COOLDOWN_FRAMES=8) and while `duck_hit`=1 -> no `shot_fired`, `ammo` unchanged; a trigger after the 8th `new_frame` is accepted.
- `score` at 255, then a hit -> remains 255; `game_start` -> `score`=0, `ammo`=3, READY. Without `CTL_SHOT_SCORE_EN`, `score` stays 0 throughout.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// -----------------------------------------------------------------------------
// duck_hunt_pkg
// Shared definitions for the duck-hunt control layer: default sprite geometry,
// ammunition and cooldown defaults, screen limits and the shot-controller
// state type.
// -----------------------------------------------------------------------------
package duck_hunt_pkg;

    localparam int DUCK_W_DEF          = 64;
    localparam int DUCK_H_DEF          = 64;
    localparam int AMMO_MAX_DEF        = 3;
    localparam int COOLDOWN_FRAMES_DEF = 8;

    localparam int X_POS_MAX = 1024;
    localparam int Y_POS_MAX = 600;

    typedef enum logic [2:0] {
        SHOT_IDLE     = 3'd0,
        SHOT_READY    = 3'd1,
        SHOT_EVAL     = 3'd2,
        SHOT_COOLDOWN = 3'd3,
        SHOT_EMPTY    = 3'd4
    } shot_state_t;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous level followed by a rising-edge
// detector. The pulse is formed from flopped values only, so it carries no
// combinational path from din.
//
// Ports:
//   clk    in  1  system clock
//   rst    in  1  synchronous active-high reset
//   din    in  1  asynchronous level input
//   pulse  out 1  one-cycle pulse on each synchronised rising edge of din
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            meta_p0 <= din;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/ctl_shot.sv
// -----------------------------------------------------------------------------
// ctl_shot
// Shot controller for duck hunt. Synchronises the gun trigger, tests the aim
// point against the duck bounding box on each accepted press, and emits one
// registered hit or miss pulse per shot. Tracks ammunition per duck and,
// optionally, a saturating score.
//
// Build option:
//   CTL_SHOT_SCORE_EN  defined: 8-bit saturating score register is present.
//                      undefined: score is tied to 0.
//
// Ports:
//   clk         in  1   system clock
//   rst         in  1   synchronous active-high reset
//   new_frame   in  1   one-cycle pulse per video frame
//   game_start  in  1   one-cycle pulse, starts or restarts the game
//   trigger     in  1   raw asynchronous trigger level
//   aim_x/y     in  10  crosshair position
//   duck_x/y    in  10  duck top-left position
//   duck_show   in  1   duck visible (rising edge reloads ammo)
//   duck_hit    in  1   duck currently falling
//   hit         out 1   one-cycle pulse, shot landed
//   miss        out 1   one-cycle pulse, shot missed
//   shot_fired  out 1   one-cycle pulse per accepted shot
//   ammo        out 2   rounds remaining
//   score       out 8   ducks hit since game_start, saturating
// -----------------------------------------------------------------------------
module ctl_shot
    import duck_hunt_pkg::*;
#(
    parameter int DUCK_W          = DUCK_W_DEF,
    parameter int DUCK_H          = DUCK_H_DEF,
    parameter int AMMO_MAX        = AMMO_MAX_DEF,
    parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       game_start,
    input  logic       trigger,
    input  logic [9:0] aim_x,
    input  logic [9:0] aim_y,
    input  logic [9:0] duck_x,
    input  logic [9:0] duck_y,
    input  logic       duck_show,
    input  logic       duck_hit,
    output logic       hit,
    output logic       miss,
    output logic       shot_fired,
    output logic [1:0] ammo,
    output logic [7:0] score
);

    localparam logic [1:0]  AMMO_FULL = 2'(AMMO_MAX);
    localparam logic [3:0]  CD_LAST   = 4'(COOLDOWN_FRAMES - 1);
    localparam logic [10:0] BOX_W     = 11'(DUCK_W);
    localparam logic [10:0] BOX_H     = 11'(DUCK_H);

    shot_state_t state, state_nxt;
    logic [1:0]  ammo_q, ammo_nxt;
    logic [3:0]  cd_cnt, cd_cnt_nxt;
    logic        hit_q, hit_nxt;
    logic        miss_q, miss_nxt;
    logic        shot_q, shot_nxt;
    logic        latch_en;
    logic        score_inc;
    logic        score_clr;

    logic        trig_edge;
    logic        show_q;
    logic        reload;

    logic [9:0]  aim_x_p0, aim_y_p0, duck_x_p0, duck_y_p0;
    logic        in_box;

    sync_edge u_trig_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (trigger),
        .pulse (trig_edge)
    );

    // A new duck appearing is what reloads the gun.
    assign reload = duck_show & ~show_q;

    // Stage p0: shot coordinates captured at acceptance
    always_ff @(posedge clk) begin
        if (latch_en) begin
            aim_x_p0  <= aim_x;
            aim_y_p0  <= aim_y;
            duck_x_p0 <= duck_x;
            duck_y_p0 <= duck_y;
        end
    end

    // Widened to 11 bits so a duck near the right/bottom edge does not wrap.
    always_comb begin
        logic [10:0] ax, ay, dx, dy;
        ax     = {1'b0, aim_x_p0};
        ay     = {1'b0, aim_y_p0};
        dx     = {1'b0, duck_x_p0};
        dy     = {1'b0, duck_y_p0};
        in_box = (ax >= dx) && (ax < dx + BOX_W) &&
                 (ay >= dy) && (ay < dy + BOX_H);
    end

    always_comb begin
        state_nxt  = state;
        ammo_nxt   = ammo_q;
        cd_cnt_nxt = cd_cnt;
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;
        shot_nxt   = 1'b0;
        latch_en   = 1'b0;
        score_inc  = 1'b0;
        score_clr  = 1'b0;

        if (game_start) begin
            // Restart from anywhere; an in-flight evaluation is dropped.
            state_nxt  = SHOT_READY;
            ammo_nxt   = AMMO_FULL;
            cd_cnt_nxt = 4'd0;
            score_clr  = 1'b1;
        end else if (state != SHOT_IDLE) begin
            if (reload) begin
                ammo_nxt = AMMO_FULL;
            end
            case (state)
                SHOT_READY: begin
                    // A reload in the same cycle swallows the trigger edge.
                    if (!reload && trig_edge && duck_show && !duck_hit &&
                        (ammo_q != 2'd0)) begin
                        latch_en  = 1'b1;
                        ammo_nxt  = ammo_q - 2'd1;
                        shot_nxt  = 1'b1;
                        state_nxt = SHOT_EVAL;
                    end
                end
                SHOT_EVAL: begin
                    if (in_box) begin
                        hit_nxt   = 1'b1;
                        score_inc = 1'b1;
                    end else begin
                        miss_nxt  = 1'b1;
                    end
                    // Frames seen during this cycle are deliberately not counted.
                    cd_cnt_nxt = 4'd0;
                    state_nxt  = SHOT_COOLDOWN;
                end
                SHOT_COOLDOWN: begin
                    if (new_frame) begin
                        if (cd_cnt == CD_LAST) begin
                            cd_cnt_nxt = 4'd0;
                            state_nxt  = (ammo_nxt != 2'd0) ? SHOT_READY : SHOT_EMPTY;
                        end else begin
                            cd_cnt_nxt = cd_cnt + 4'd1;
                        end
                    end
                end
                SHOT_EMPTY: begin
                    if (reload) begin
                        state_nxt = SHOT_READY;
                    end
                end
                default: begin
                    state_nxt = SHOT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SHOT_IDLE;
            ammo_q <= AMMO_FULL;
            cd_cnt <= 4'd0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            shot_q <= 1'b0;
            show_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ammo_q <= ammo_nxt;
            cd_cnt <= cd_cnt_nxt;
            hit_q  <= hit_nxt;
            miss_q <= miss_nxt;
            shot_q <= shot_nxt;
            show_q <= duck_show;
        end
    end

    assign hit        = hit_q;
    assign miss       = miss_q;
    assign shot_fired = shot_q;
    assign ammo       = ammo_q;

`ifdef CTL_SHOT_SCORE_EN
    logic [7:0] score_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || score_clr) begin
            score_q <= 8'd0;
        end else if (score_inc) begin
            score_q <= sat_inc8(score_q);
        end
    end

    assign score = score_q;
`else
    logic score_unused;
    assign score_unused = score_inc | score_clr;
    assign score        = 8'd0;
`endif

endmodule

// File: tb/tb_ctl_shot.sv
module tb_ctl_shot;

    localparam int DW  = 64;
    localparam int DH  = 64;
    localparam int AMX = 3;
    localparam int CDF = 8;
`ifdef CTL_SHOT_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, new_frame, game_start, trigger;
    logic [9:0] aim_x, aim_y, duck_x, duck_y;
    logic       duck_show, duck_hit;
    logic       hit, miss, shot_fired;
    logic [1:0] ammo;
    logic [7:0] score;

    ctl_shot #(
        .DUCK_W(DW), .DUCK_H(DH), .AMMO_MAX(AMX), .COOLDOWN_FRAMES(CDF)
    ) dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .game_start(game_start),
        .trigger(trigger), .aim_x(aim_x), .aim_y(aim_y), .duck_x(duck_x),
        .duck_y(duck_y), .duck_show(duck_show), .duck_hit(duck_hit),
        .hit(hit), .miss(miss), .shot_fired(shot_fired), .ammo(ammo),
        .score(score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected shot: kind 0 = normal, 1 = aborted by game_start/rst.
    typedef struct packed {
        logic       exp_hit;
        logic [1:0] kind;
        logic [1:0] ammo;
        logic [7:0] score;
        int         deadline;
    } shot_exp_t;

    typedef struct packed {
        logic [1:0] ammo;
        logic [7:0] score;
    } snap_t;

    shot_exp_t exp_q[$];
    snap_t     snap_q[$];
    int        checks = 0;
    int        errors = 0;
    bit        end_chk = 1'b0;

    // Reference model: game phase, ammo, score, frames left in cooldown.
    typedef enum int {M_IDLE, M_READY, M_COOL, M_EMPTY} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_ammo  = AMX;
    int      m_score = 0;
    int      m_rem   = 0;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit inside_box(int ax, int ay);
        int dx = int'(duck_x);
        int dy = int'(duck_y);
        return (ax >= dx) && (ax < dx + DW) && (ay >= dy) && (ay < dy + DH);
    endfunction

    function automatic void m_frame();
        if (m_phase == M_COOL) begin
            m_rem--;
            if (m_rem == 0) m_phase = (m_ammo > 0) ? M_READY : M_EMPTY;
        end
    endfunction

    function automatic void m_start();
        m_phase = M_READY;
        m_ammo  = AMX;
        m_score = 0;
        m_rem   = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            tick();
            new_frame = 1'b0;
            m_frame();
            tick();
        end
    endtask

    task automatic start();
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        m_start();
        tick();
    endtask

    task automatic set_show(input bit v);
        if (v && !duck_show && m_phase != M_IDLE) begin
            m_ammo = AMX;
            if (m_phase == M_EMPTY) m_phase = M_READY;
        end
        duck_show = v;
        tick();
        tick();
    endtask

    task automatic snap();
        snap_q.push_back({2'(m_ammo), 8'(m_score)});
        tick();
        tick();
    endtask

    // mid: 0 none, 1 game_start in EVAL cycle, 2 rst in EVAL cycle,
    //      3 new_frame in EVAL cycle
    task automatic shot(input int ax, input int ay, input int hold, input int mid);
        bit acc;
        bit h;
        aim_x   = 10'(ax);
        aim_y   = 10'(ay);
        trigger = 1'b1;
        acc = (m_phase == M_READY) && duck_show && !duck_hit;
        if (acc) begin
            h = inside_box(ax, ay);
            m_ammo--;
            if (h && SCORE_ON && m_score < 255) m_score++;
            exp_q.push_back({h, ((mid == 1 || mid == 2) ? 2'd1 : 2'd0),
                             2'(m_ammo), 8'(m_score), cyc + 4});
            m_phase = M_COOL;
            m_rem   = CDF;
        end
        tick();
        tick();
        tick();
        case (mid)
            1: game_start = 1'b1;
            2: rst        = 1'b1;
            3: new_frame  = 1'b1;
            default: ;
        endcase
        tick();
        game_start = 1'b0;
        rst        = 1'b0;
        new_frame  = 1'b0;
        if (mid == 1) m_start();
        if (mid == 2) begin
            m_phase = M_IDLE;
            m_ammo  = AMX;
            m_score = 0;
        end
        if (mid == 3 && !acc) m_frame();
        repeat (hold) tick();
        trigger = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor / scoreboard
    initial begin
        shot_exp_t pe;
        snap_t     s;
        bit        pend = 1'b0;
        bit        end_done = 1'b0;
        pe = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (pe.kind == 2'd1) begin
                    chk("abort_hit", hit, 0);
                    chk("abort_miss", miss, 0);
                end else begin
                    chk("hit", hit, pe.exp_hit);
                    chk("miss", miss, !pe.exp_hit);
                    chk("score", score, pe.score);
                end
                pend = 1'b0;
            end else if (hit || miss) begin
                chk("spurious_hit_miss", {hit, miss}, 0);
            end
            if (shot_fired) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_shot", shot_fired, 0);
                end else begin
                    pe = exp_q.pop_front();
                    chk("ammo_at_shot", ammo, pe.ammo);
                    pend = 1'b1;
                end
            end
            if (exp_q.size() > 0 && exp_q[0].deadline < cyc) begin
                chk("shot_missing", cyc, exp_q[0].deadline);
                void'(exp_q.pop_front());
            end
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk("snap_ammo", ammo, s.ammo);
                chk("snap_score", score, s.score);
                chk("snap_pulses", {hit, miss, shot_fired}, 0);
            end
            if (end_chk && !end_done) begin
                chk("pending_at_end", exp_q.size() + int'(pend), 0);
                end_done = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // Stimulus
    initial begin
        int r, ax, ay;
        rst = 1'b1; new_frame = 1'b0; game_start = 1'b0; trigger = 1'b0;
        aim_x = '0; aim_y = '0; duck_x = '0; duck_y = '0;
        duck_show = 1'b0; duck_hit = 1'b0;
        repeat (3) tick();
        snap();
        rst = 1'b0;
        tick();

        // Basic hit with a long hold, miss on right boundary, inner corner hit
        duck_x = 10'd100; duck_y = 10'd200;
        set_show(1'b1);
        start();
        snap();
        shot(130, 230, 20, 0);
        frames(CDF);
        shot(164, 230, 2, 0);
        frames(CDF);
        shot(163, 263, 2, 0);
        frames(CDF);
        // Out of ammo: dropped trigger, then reload via a new duck
        shot(130, 230, 2, 0);
        snap();
        set_show(1'b0);
        set_show(1'b1);
        snap();
        shot(130, 230, 2, 0);
        frames(CDF);

        // Bottom-right screen corner: box end exceeds 10 bits
        duck_x = 10'd1000; duck_y = 10'd590;
        shot(1020, 599, 2, 0);
        frames(CDF);

        // Cooldown length, frame in EVAL ignored, duck_hit blocks
        shot(1010, 595, 2, 3);
        frames(CDF - 1);
        shot(1010, 595, 2, 0);
        frames(1);
        duck_hit = 1'b1;
        tick();
        shot(1010, 595, 2, 0);
        duck_hit = 1'b0;
        tick();
        shot(990, 595, 2, 0);
        frames(CDF);
        snap();

        // Restart and reset landing in the EVAL cycle
        set_show(1'b0);
        set_show(1'b1);
        shot(1010, 595, 2, 1);
        snap();
        shot(1010, 595, 2, 2);
        snap();
        start();

        // Score saturation
        duck_x = 10'd100; duck_y = 10'd200;
        for (int i = 0; i < 258; i++) begin
            shot(130, 230, 0, 0);
            frames(CDF);
            if (m_phase == M_EMPTY) begin
                set_show(1'b0);
                set_show(1'b1);
            end
        end
        snap();
        start();
        snap();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                ax = clamp(int'(duck_x) + int'($urandom_range(0, 2 * DW)) - DW / 2, 0, 1023);
                ay = clamp(int'(duck_y) + int'($urandom_range(0, 2 * DH)) - DH / 2, 0, 1023);
                shot(ax, ay, $urandom_range(0, 6),
                     ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0);
            end else if (r <= 5) begin
                frames($urandom_range(1, 4));
            end else if (r == 6) begin
                set_show(1'($urandom_range(0, 3) != 0));
            end else if (r == 7) begin
                duck_hit = ($urandom_range(0, 3) == 0);
                tick();
            end else if (r == 8) begin
                duck_x = 10'($urandom_range(0, 1023));
                duck_y = 10'($urandom_range(0, 599));
                tick();
            end else begin
                if ($urandom_range(0, 3) == 0) start();
                else snap();
            end
        end
        frames(CDF);
        snap();

        repeat (8) tick();
        end_chk = 1'b1;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
